hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage pipelined core. It sequences the F/D, D/E, E/M and M/W pipeline registers through stall and flush enables, and resolves four kinds of hazard: load-use, taken branch/jump redirect, data-memory wait states and multi-cycle ALU operations. It also produces the E-stage operand forwarding selects, a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush sequencing for memory waits,
// multi-cycle ALU ops, redirects and load-use, plus E-stage operand forwarding.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MulStartE,
  input  logic             MulDoneE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemErr
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MUL_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               resume_q, resume_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic mem_cond, mul_busy;
  logic mem_pat, mul_pat, lower_en;
  logic redirect, load_use;

  assign mem_cond = MemReqM && !MemReadyM;
  assign mul_busy = !MulDoneE && ((state_q == MUL_WAIT) || MulStartE);

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    resume_d = resume_q;
    err_d    = err_q;
    mem_pat  = 1'b0;
    mul_pat  = 1'b0;
    lower_en = 1'b0;
    if (state_q == MEM_WAIT) begin
      if (!MemReadyM && (wait_q != WAIT_LAST)) begin
        mem_pat = 1'b1;
        wait_d  = wait_q + WAIT_W'(1);
      end else begin
        // Ready or abandoned: release now, resume a still-busy multiply afterwards.
        lower_en = 1'b1;
        wait_d   = '0;
        resume_d = 1'b0;
        if (!MemReadyM) err_d = 1'b1;
        state_d  = (resume_q && !MulDoneE) ? MUL_WAIT : RUN;
      end
    end else if (mem_cond) begin
      mem_pat  = 1'b1;
      resume_d = (state_q == MUL_WAIT) && !MulDoneE;
      state_d  = MEM_WAIT;
    end else if (mul_busy) begin
      mul_pat = 1'b1;
      state_d = MUL_WAIT;
    end else begin
      lower_en = 1'b1;
      state_d  = RUN;
    end
  end

  // A redirect squashes the wrong-path instruction in D, so it masks load-use.
  assign redirect = lower_en && PCSrcE;
  assign load_use = lower_en && !PCSrcE && (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF = RST_N && (mem_pat || mul_pat || load_use);
    StallD = RST_N && (mem_pat || mul_pat || load_use);
    StallE = RST_N && (mem_pat || mul_pat);
    StallM = RST_N && mem_pat;
    FlushD = RST_N && redirect;
    FlushE = RST_N && (redirect || load_use);
    FlushM = RST_N && mul_pat;
    FlushW = RST_N && mem_pat;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) return 2'b10;
    if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE  = fwd_sel(Rs1E);
  assign ForwardBE  = fwd_sel(Rs2E);
  assign StallCount = stall_cnt_q;
  assign MemErr     = err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      wait_q      <= '0;
      resume_q    <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      resume_q    <= resume_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic CLK, RST_N;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, MulStartE, MulDoneE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [TB_CNT_W-1:0] StallCount;
  logic MemErr;

  hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .MulDoneE(MulDoneE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount), .MemErr(MemErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst_n;
    bit [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    bit [1:0] result_src_e;
    bit       pc_src_e, mul_start_e, mul_done_e, reg_write_m, reg_write_w;
    bit       mem_req_m, mem_ready_m;
  } in_t;

  // sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
  typedef struct {
    int       cyc;
    bit [7:0] sf;
    bit [1:0] fa, fb;
    int       cnt;
    bit       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   drv_cyc = 0;

  // Reference model: "busy" flags and a per-access stalled-cycle tally.
  bit m_in_mem, m_in_mul, m_resume_mul, m_err;
  int m_mem_cycles, m_cnt;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  function automatic bit [1:0] ref_fwd(input bit [4:0] rs, input in_t s);
    if (s.reg_write_m && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
    if (s.reg_write_w && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input in_t s, output exp_t e);
    bit mem_stall, mul_stall, lower, redirect, load_use;
    e = '{default: 0};
    e.fa = ref_fwd(s.rs1_e, s);
    e.fb = ref_fwd(s.rs2_e, s);
    if (!s.rst_n) begin
      m_in_mem = 0; m_in_mul = 0; m_resume_mul = 0; m_err = 0;
      m_mem_cycles = 0; m_cnt = 0;
      return;
    end
    e.cnt = m_cnt;
    e.err = m_err;
    mem_stall = 0; mul_stall = 0; lower = 0;
    if (m_in_mem) begin
      // An access may hold the pipe for at most TB_TIMEOUT cycles in total.
      if (!s.mem_ready_m && m_mem_cycles < TB_TIMEOUT) begin
        mem_stall = 1;
        m_mem_cycles++;
      end else begin
        if (!s.mem_ready_m) m_err = 1;
        lower = 1;
        m_in_mem = 0;
        m_in_mul = m_resume_mul && !s.mul_done_e;
        m_resume_mul = 0;
      end
    end else if (s.mem_req_m && !s.mem_ready_m) begin
      mem_stall = 1;
      m_resume_mul = m_in_mul && !s.mul_done_e;
      m_in_mul = 0;
      m_in_mem = 1;
      m_mem_cycles = 1;
    end else if (!s.mul_done_e && (m_in_mul || s.mul_start_e)) begin
      mul_stall = 1;
      m_in_mul = 1;
    end else begin
      lower = 1;
      m_in_mul = 0;
    end
    redirect = lower && s.pc_src_e;
    load_use = lower && !s.pc_src_e && s.result_src_e == 2'b01 && s.rd_e != 0 &&
               (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
    e.sf = {mem_stall | mul_stall | load_use, mem_stall | mul_stall | load_use,
            mem_stall | mul_stall, mem_stall, redirect, redirect | load_use,
            mul_stall, mem_stall};
    if (e.sf[7] && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic step(input in_t s);
    exp_t e;
    @(posedge CLK);
    #1;
    RST_N = s.rst_n; Rs1D = s.rs1_d; Rs2D = s.rs2_d; Rs1E = s.rs1_e; Rs2E = s.rs2_e;
    RdE = s.rd_e; RdM = s.rd_m; RdW = s.rd_w; ResultSrcE = s.result_src_e;
    PCSrcE = s.pc_src_e; MulStartE = s.mul_start_e; MulDoneE = s.mul_done_e;
    RegWriteM = s.reg_write_m; RegWriteW = s.reg_write_w;
    MemReqM = s.mem_req_m; MemReadyM = s.mem_ready_m;
    model_step(s, e);
    e.cyc = drv_cyc++;
    exp_q.push_back(e);
  endtask

  function automatic in_t idle();
    in_t s = '{default: 0};
    s.rst_n = 1;
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.rst_n        = ($urandom_range(0, 79) != 0);
    s.rs1_d        = 5'($urandom_range(0, 3));
    s.rs2_d        = 5'($urandom_range(0, 3));
    s.rs1_e        = 5'($urandom_range(0, 3));
    s.rs2_e        = 5'($urandom_range(0, 3));
    s.rd_e         = 5'($urandom_range(0, 3));
    s.rd_m         = 5'($urandom_range(0, 3));
    s.rd_w         = 5'($urandom_range(0, 3));
    s.result_src_e = 2'($urandom_range(0, 3));
    s.pc_src_e     = ($urandom_range(0, 4) == 0);
    s.mul_start_e  = ($urandom_range(0, 4) == 0);
    s.mul_done_e   = ($urandom_range(0, 2) == 0);
    s.reg_write_m  = 1'($urandom_range(0, 1));
    s.reg_write_w  = 1'($urandom_range(0, 1));
    s.mem_req_m    = ($urandom_range(0, 3) == 0);
    s.mem_ready_m  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Monitor: every cycle is a DUT response; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall_flush", e.cyc,
              32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}), 32'(e.sf));
        check("fwd_a", e.cyc, 32'(ForwardAE), 32'(e.fa));
        check("fwd_b", e.cyc, 32'(ForwardBE), 32'(e.fb));
        check("stall_count", e.cyc, 32'(StallCount), 32'(e.cnt));
        check("mem_err", e.cyc, 32'(MemErr), 32'(e.err));
      end
    end
  end

  initial begin
    in_t s;
    RST_N = 1'b0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = '0; PCSrcE = 0; MulStartE = 0; MulDoneE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;

    // Reset: hazards masked, forwarding still live.
    s = idle(); s.rst_n = 0; s.mem_req_m = 1; s.rs1_e = 7; s.rd_m = 7; s.reg_write_m = 1;
    step(s); step(s);

    // Load-use for one cycle, then the bubble clears it; RdE=0 never stalls.
    s = idle(); s.result_src_e = 2'b01; s.rd_e = 5; s.rs1_d = 5; step(s);
    s = idle(); step(s);
    s = idle(); s.result_src_e = 2'b01; s.rd_e = 0; s.rs1_d = 0; step(s);

    // Forwarding priority.
    s = idle(); s.rd_m = 7; s.rd_w = 7; s.rs1_e = 7; s.reg_write_m = 1; s.reg_write_w = 1;
    s.rs2_e = 3; step(s);
    s.reg_write_m = 0; step(s);

    // Redirect together with load-use.
    s = idle(); s.pc_src_e = 1; s.result_src_e = 2'b01; s.rd_e = 4; s.rs2_d = 4; step(s);

    // Memory wait: three cycles not ready, then ready.
    s = idle(); s.mem_req_m = 1;
    repeat (3) step(s);
    s.mem_ready_m = 1; step(s);
    s = idle(); step(s);

    // Timeout: ready never comes; the abandoned access sets a sticky error.
    s = idle(); s.mem_req_m = 1;
    repeat (TB_TIMEOUT + 1) step(s);
    s = idle(); repeat (3) step(s);
    s.rst_n = 0; step(s);
    s = idle(); step(s);

    // Multiply held five cycles with a two-cycle memory wait from cycle 2.
    s = idle(); s.mul_start_e = 1; step(s); step(s);
    s.mem_req_m = 1; step(s); step(s);
    s.mem_ready_m = 1; step(s);
    s.mem_req_m = 0; s.mem_ready_m = 0; step(s);
    s.mul_done_e = 1; step(s);
    s = idle(); step(s);

    // Memory ready and multiply done together after a nested wait.
    s = idle(); s.mul_start_e = 1; step(s);
    s.mem_req_m = 1; step(s);
    s.mem_ready_m = 1; s.mul_done_e = 1; step(s);
    s = idle(); step(s);

    // Randomized traffic; stall count saturates along the way.
    repeat (600) step(rand_in());

    repeat (3) @(posedge CLK);
    check("queue_drained", drv_cyc, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
